// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decoder/pipeline control and the hazard scoreboard.
// master drives the decoded instruction; slave returns stall and the forwarding selects.
interface hazard_scoreboard_if #(
   parameter int NRD    = 2,
   parameter int RSEL_W = 5,
   parameter int FSEL_W = 2
);
   logic                  adv;
   logic                  issue_valid;
   logic                  issue_wen;
   logic [RSEL_W-1:0]     issue_wsel;
   logic                  issue_load;
   logic                  flush;
   logic [NRD*RSEL_W-1:0] rsel;
   logic                  stall;
   logic [NRD*FSEL_W-1:0] fwd_sel;

   modport master (
      output adv, issue_valid, issue_wen, issue_wsel, issue_load, flush, rsel,
      input  stall, fwd_sel
   );

   modport slave (
      input  adv, issue_valid, issue_wen, issue_wsel, issue_load, flush, rsel,
      output stall, fwd_sel
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers across DEPTH post-decode stages; drives forwarding selects and load-use stall.
// Optional stall/forward counters are compiled in with HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
   parameter int DEPTH      = 3,
   parameter int NRD        = 2,
   parameter int RSEL_W     = 5,
   parameter int LOAD_READY = 2,
   parameter int FSEL_W     = $clog2(DEPTH+1)
) (
   input  logic               CLK,
   input  logic               RST,
   hazard_scoreboard_if.slave sb
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        fwd_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic [RSEL_W-1:0] wsel;
      logic              load;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [FSEL_W-1:0] port_sel [NRD];
   logic [NRD-1:0]    port_hazard;
   logic              stall;
   logic              insert;

   // Scan oldest to youngest so the youngest matching writer overrides older ones.
   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer latches.
      port_hazard = '0;
      for (int p = 0; p < NRD; p++) begin
         port_sel[p] = '0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if ((sb.rsel[p*RSEL_W +: RSEL_W] != '0) && ent_q[k].valid &&
                (ent_q[k].wsel == sb.rsel[p*RSEL_W +: RSEL_W])) begin
               port_sel[p]    = FSEL_W'(k+1);
               port_hazard[p] = ent_q[k].load && (k < LOAD_READY);
            end
         end
      end
   end

   always_comb begin
      sb.fwd_sel = '0;
      for (int p = 0; p < NRD; p++) sb.fwd_sel[p*FSEL_W +: FSEL_W] = port_sel[p];
   end

   assign stall    = sb.issue_valid & ~sb.flush & (|port_hazard);
   assign sb.stall = stall;
   assign insert   = sb.issue_valid & sb.issue_wen & (sb.issue_wsel != '0) & ~sb.flush & ~stall;

   always_comb begin
      ent_d[0]       = '0;
      ent_d[0].valid = insert;
      ent_d[0].wsel  = insert ? sb.issue_wsel : '0;
      ent_d[0].load  = insert & sb.issue_load;
      for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
   end

   // NOTE: the entry array is reset explicitly because an asserted RST must invalidate every tracked writer at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else if (sb.adv) begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's pre-edge value.
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   // Both counters saturate instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (sb.adv && stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (sb.adv && !stall && sb.issue_valid && (sb.fwd_sel != '0) && (fwd_cnt_q != 32'hFFFF_FFFF))
         fwd_cnt_d = fwd_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
